// File: rtl/router_out_arbiter.sv
// router_out_arbiter
// Crossbar scheduler for the 16-port serial router. Each output port keeps
// its own round-robin pointer and IDLE/OWNED state. An output is granted to
// at most one requesting input, and the grant is held until that input
// signals end-of-frame.
//
// Ports:
//   clock      - sole clock, all state on posedge
//   reset      - synchronous, active-high
//   req_valid  - [NPORT] input i requests the output named by req_addr[i]
//   req_addr   - [NPORT*AW] destination of input i in bits [i*AW +: AW]
//   release_i  - [NPORT] one-cycle end-of-frame pulse from input i
//                ("release" is a reserved SystemVerilog keyword)
//   grant      - [NPORT] input i currently owns its requested output
//   src_sel    - [NPORT*AW] owning input of output o in bits [o*AW +: AW], 0 when idle
//   busy_n     - [NPORT] active-low, 0 while output o is owned
//   timeout    - [NPORT] one-cycle pulse when output o's grant is revoked by the watchdog
//
// Optional feature: define ARB_TIMEOUT_EN to add a per-output hold watchdog
// of MAX_HOLD cycles. Without it, timeout is tied to 0 and grants persist
// until release.
module router_out_arbiter #(
  parameter int NPORT    = 16,
  parameter int AW       = 4,
  parameter int MAX_HOLD = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPORT-1:0]      req_valid,
  input  logic [NPORT*AW-1:0]   req_addr,
  input  logic [NPORT-1:0]      release_i,
  output logic [NPORT-1:0]      grant,
  output logic [NPORT*AW-1:0]   src_sel,
  output logic [NPORT-1:0]      busy_n,
  output logic [NPORT-1:0]      timeout
);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

  state_e        state_q [NPORT];
  state_e        state_d [NPORT];
  logic [AW-1:0] owner_q [NPORT];
  logic [AW-1:0] owner_d [NPORT];
  logic [AW-1:0] ptr_q   [NPORT];
  logic [AW-1:0] ptr_d   [NPORT];
  logic [NPORT-1:0] revoke;

  if (AW != $clog2(NPORT) || MAX_HOLD < 1) begin : g_bad_cfg
    $error("router_out_arbiter: AW must equal clog2(NPORT) and MAX_HOLD must be positive");
  end

  // Outputs come straight from the state registers, so no input reaches an
  // output combinationally. owner_q is kept at 0 while idle so src_sel reads 0.
  always_comb begin
    grant   = '0;
    src_sel = '0;
    busy_n  = '1;
    for (int o = 0; o < NPORT; o++) begin
      src_sel[o*AW +: AW] = owner_q[o];
      if (state_q[o] == OWNED) begin
        busy_n[o]         = 1'b0;
        grant[owner_q[o]] = 1'b1;
      end
    end
  end

  // Per-output next state. An owned output only goes idle on this edge; it
  // arbitrates again on the following edge, which gives the dead cycle
  // between frames. An input that already holds a grant (including one
  // releasing this cycle) is not a candidate, so it can never own two outputs.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < NPORT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      case (state_q[o])
        OWNED: begin
          if (release_i[owner_q[o]] || revoke[o]) begin
            state_d[o] = IDLE;
            owner_d[o] = '0;
          end
        end
        default: begin
          found = 1'b0;
          for (int k = 0; k < NPORT; k++) begin
            idx = int'(ptr_q[o]) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!found && req_valid[idx] && !grant[idx] &&
                (req_addr[idx*AW +: AW] == AW'(o))) begin
              found      = 1'b1;
              state_d[o] = OWNED;
              owner_d[o] = AW'(idx);
              ptr_d[o]   = (idx == NPORT - 1) ? '0 : AW'(idx + 1);
            end
          end
        end
      endcase
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0]    hold_q [NPORT];
  logic [HW-1:0]    hold_d [NPORT];
  logic [NPORT-1:0] timeout_q;
  logic [NPORT-1:0] timeout_d;

  // Hold counter counts OWNED cycles from zero. Revocation happens on the
  // edge where MAX_HOLD owned cycles have elapsed. A genuine release on that
  // same edge wins, so no timeout pulse is raised for it.
  always_comb begin
    revoke    = '0;
    timeout_d = '0;
    for (int o = 0; o < NPORT; o++) begin
      hold_d[o] = '0;
      if (state_q[o] == OWNED) begin
        hold_d[o] = hold_q[o] + 1'b1;
        if (hold_q[o] == HW'(MAX_HOLD - 1)) begin
          revoke[o]    = 1'b1;
          timeout_d[o] = !release_i[owner_q[o]];
        end
      end
    end
  end

  // Watchdog counters and the timeout pulse register.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_q <= '0;
      for (int o = 0; o < NPORT; o++) hold_q[o] <= '0;
    end else begin
      timeout_q <= timeout_d;
      for (int o = 0; o < NPORT; o++) hold_q[o] <= hold_d[o];
    end
  end

  assign timeout = timeout_q;
`else
  assign revoke  = '0;
  assign timeout = '0;
`endif

endmodule
